// File: rtl/inbuff_rd_ctrl.sv
// Read-side controller between the input data buffer and the EC engine.
// Pops words while enabled, tags each with its column index and first/last
// markers, and hands them to the engine through a 2-entry registered skid.
module inbuff_rd_ctrl #(
  parameter int K_MAX         = 128,
  parameter int K_MIN         = 2,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int DATA_W        = W * PACKET_LENGTH,
  parameter int K_W           = $clog2(K_MAX + 1),
  parameter int COL_W         = $clog2(K_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cntrl_inbuff_rd_en,
  input  logic [K_W-1:0]    k_cfg,
  input  logic              inbuff_empty,
  output logic              inbuff_rd,
  input  logic [DATA_W-1:0] inbuff_data,
  output logic              eng_data_vld,
  input  logic              eng_data_rdy,
  output logic [DATA_W-1:0] eng_data,
  output logic [COL_W-1:0]  eng_col_idx,
  output logic              eng_first,
  output logic              eng_last,
  output logic [15:0]       stripe_cnt,
  output logic              rd_idle,
  output logic              cfg_err
);

  // One skid entry: {data, column, first, last}
  localparam int ENT_W = DATA_W + COL_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic               latch_k;
  logic [K_W-1:0]     k_lat_reg;
  logic [K_W-1:0]     k_clamp;
  logic               k_bad;
  logic               cfg_err_reg;
  logic [COL_W-1:0]   col_cnt_reg;
  logic               col_is_last;
  logic               inflight_reg;
  logic [COL_W-1:0]   if_col_reg;
  logic               if_first_reg;
  logic               if_last_reg;
  logic [1:0]         occ_reg;
  logic [ENT_W-1:0]   head_reg;
  logic [ENT_W-1:0]   tail_reg;
  logic [ENT_W-1:0]   in_entry;
  logic [15:0]        stripe_cnt_reg;
  logic               xfer;
  logic               pipe_empty;
  logic               want_pop;
  logic               room;
  logic [2:0]         pending;

  assign xfer        = (occ_reg != 2'd0) && eng_data_rdy;
  assign pipe_empty  = !inflight_reg && (occ_reg == 2'd0);
  assign col_is_last = (K_W'(col_cnt_reg) == (k_lat_reg - K_W'(1)));

  // Count the head word leaving this cycle as free space so that a steady
  // rdy=1 stream sustains one pop per cycle; with rdy=0 the skid plus the
  // outstanding read never exceed two words.
  assign pending = 3'(occ_reg) + 3'(inflight_reg) - 3'(xfer);
  assign room    = (pending < 3'd2);

  assign want_pop  = ((state_reg == RUN) && cntrl_inbuff_rd_en) ||
                     ((state_reg == DRAIN) && (col_cnt_reg != '0));
  assign inbuff_rd = want_pop && !inbuff_empty && room;

  assign in_entry = {inbuff_data, if_col_reg, if_first_reg, if_last_reg};

  // Clamp the requested stripe width into the supported range
  always_comb begin
    k_clamp = k_cfg;
    k_bad   = 1'b0;
    if (k_cfg < K_W'(K_MIN)) begin
      k_clamp = K_W'(K_MIN);
      k_bad   = 1'b1;
    end else if (k_cfg > K_W'(K_MAX)) begin
      k_clamp = K_W'(K_MAX);
      k_bad   = 1'b1;
    end
  end

  // Next-state logic; partial stripes are always completed before idling
  always_comb begin
    state_next = state_reg;
    latch_k    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cntrl_inbuff_rd_en) begin
          state_next = RUN;
          latch_k    = 1'b1;
        end
      end
      RUN: begin
        if (!cntrl_inbuff_rd_en) begin
          if (col_cnt_reg != '0) state_next = DRAIN;
          else if (pipe_empty)   state_next = IDLE;
        end
      end
      DRAIN: begin
        if (cntrl_inbuff_rd_en)                          state_next = RUN;
        else if ((col_cnt_reg == '0) && pipe_empty)      state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus stripe-width latch and sticky config error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      k_lat_reg   <= K_W'(K_MIN);
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch_k) begin
        k_lat_reg <= k_clamp;
        if (k_bad) cfg_err_reg <= 1'b1;
      end
    end
  end

  // Column counter advances on every pop and wraps after the last column
  always_ff @(posedge clk) begin
    if (rst)           col_cnt_reg <= '0;
    else if (inbuff_rd) col_cnt_reg <= col_is_last ? '0 : col_cnt_reg + COL_W'(1);
  end

  // In-flight stage: the tag waits here while the buffer returns the data
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg <= 1'b0;
      if_col_reg   <= '0;
      if_first_reg <= 1'b0;
      if_last_reg  <= 1'b0;
    end else begin
      inflight_reg <= inbuff_rd;
      if (inbuff_rd) begin
        if_col_reg   <= col_cnt_reg;
        if_first_reg <= (col_cnt_reg == '0);
        if_last_reg  <= col_is_last;
      end
    end
  end

  // Two-entry skid; the head register drives the engine outputs directly
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg  <= 2'd0;
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      case (occ_reg)
        2'd0: begin
          if (inflight_reg) begin
            head_reg <= in_entry;
            occ_reg  <= 2'd1;
          end
        end
        2'd1: begin
          if (inflight_reg && xfer) begin
            head_reg <= in_entry;
          end else if (inflight_reg) begin
            tail_reg <= in_entry;
            occ_reg  <= 2'd2;
          end else if (xfer) begin
            occ_reg <= 2'd0;
          end
        end
        default: begin
          if (xfer) begin
            head_reg <= tail_reg;
            if (inflight_reg) tail_reg <= in_entry;
            else              occ_reg  <= 2'd1;
          end
        end
      endcase
    end
  end

  // Completed-stripe counter, bumped when a last-column word is accepted
  always_ff @(posedge clk) begin
    if (rst)                         stripe_cnt_reg <= 16'd0;
    else if (xfer && head_reg[0])    stripe_cnt_reg <= stripe_cnt_reg + 16'd1;
  end

  assign eng_data_vld = (occ_reg != 2'd0);
  assign eng_data     = head_reg[ENT_W-1 -: DATA_W];
  assign eng_col_idx  = head_reg[COL_W+1 -: COL_W];
  assign eng_first    = head_reg[1];
  assign eng_last     = head_reg[0];
  assign stripe_cnt   = stripe_cnt_reg;
  assign cfg_err      = cfg_err_reg;
  assign rd_idle      = (state_reg == IDLE) && pipe_empty;

endmodule

// File: tb/tb_inbuff_rd_ctrl.sv
// Scoreboard bench for inbuff_rd_ctrl: a queue-based input buffer model,
// expected tagged words queued at load time and compared on each transfer.
module tb_inbuff_rd_ctrl;

  localparam int DATA_W = 8;
  localparam int COL_W  = 7;
  localparam int K_W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cntrl_inbuff_rd_en;
  logic [K_W-1:0]    k_cfg;
  logic              inbuff_empty;
  logic              inbuff_rd;
  logic [DATA_W-1:0] inbuff_data = '0;
  logic              eng_data_vld;
  logic              eng_data_rdy;
  logic [DATA_W-1:0] eng_data;
  logic [COL_W-1:0]  eng_col_idx;
  logic              eng_first;
  logic              eng_last;
  logic [15:0]       stripe_cnt;
  logic              rd_idle;
  logic              cfg_err;

  inbuff_rd_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .cntrl_inbuff_rd_en (cntrl_inbuff_rd_en),
    .k_cfg              (k_cfg),
    .inbuff_empty       (inbuff_empty),
    .inbuff_rd          (inbuff_rd),
    .inbuff_data        (inbuff_data),
    .eng_data_vld       (eng_data_vld),
    .eng_data_rdy       (eng_data_rdy),
    .eng_data           (eng_data),
    .eng_col_idx        (eng_col_idx),
    .eng_first          (eng_first),
    .eng_last           (eng_last),
    .stripe_cnt         (stripe_cnt),
    .rd_idle            (rd_idle),
    .cfg_err            (cfg_err)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Input buffer model and scoreboard
  logic [DATA_W-1:0] fifo_q[$];
  int                fifo_n = 0;
  logic [31:0]       exp_q[$];
  int                exp_col = 0;
  int                cyc = 0;
  int                pops = 0;
  int                xfers = 0;
  int                first_rd_cyc = -1;
  int                first_vld_cyc = -1;
  int                last_xfer_cyc = 0;
  bit                prev_stall = 1'b0;
  logic [31:0]       prev_word = '0;
  logic [31:0]       cur_word;

  assign inbuff_empty = (fifo_n == 0);
  assign cur_word     = {15'd0, eng_data, eng_col_idx, eng_first, eng_last};

  // Buffer read: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) pops <= 0;
    else if (inbuff_rd) pops <= pops + 1;
    if (inbuff_rd && (fifo_q.size() > 0)) begin
      inbuff_data <= fifo_q.pop_front();
      fifo_n      <= fifo_n - 1;
    end
  end

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      xfers      = 0;
    end else begin
      if (inbuff_rd) begin
        check("rd_nonempty", 32'(inbuff_empty), 32'd0);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (eng_data_vld && (first_vld_cyc < 0)) first_vld_cyc = cyc;
      if (prev_stall) begin
        check("stall_vld", 32'(eng_data_vld), 32'd1);
        check("stall_hold", cur_word, prev_word);
      end
      if (!eng_data_rdy) check("max_buffered", 32'((pops - xfers) <= 2), 32'd1);
      if (eng_data_vld && eng_data_rdy) begin
        $display("xfer data=%h col=%0d first=%0d last=%0d stripes=%0d",
                 eng_data, eng_col_idx, eng_first, eng_last, stripe_cnt);
        check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("xfer_word", cur_word, exp_q.pop_front());
        xfers++;
        last_xfer_cyc = cyc;
      end
      prev_stall = eng_data_vld && !eng_data_rdy;
      prev_word  = cur_word;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put n words into the buffer; optionally queue their expected tags for stripe width k
  task automatic load(input int n, input int base, input int k, input bit track);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(DATA_W'(base + i));
      fifo_n++;
      if (track) begin
        e = {15'd0, DATA_W'(base + i), COL_W'(exp_col), (exp_col == 0), (exp_col == k - 1)};
        exp_q.push_back(e);
        exp_col = (exp_col == k - 1) ? 0 : exp_col + 1;
      end
    end
  endtask

  task automatic wait_sb(input string tag);
    int n = 0;
    while ((exp_q.size() != 0) && (n < 600)) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!rd_idle && (n < 600)) begin
      tick();
      n++;
    end
    check(tag, 32'(rd_idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int n;
    rst = 1'b1;
    cntrl_inbuff_rd_en = 1'b0;
    k_cfg = 8'd4;
    eng_data_rdy = 1'b1;
    repeat (3) tick();
    check("rst_vld", 32'(eng_data_vld), 32'd0);
    check("rst_rd", 32'(inbuff_rd), 32'd0);
    check("rst_idle", 32'(rd_idle), 32'd1);
    check("rst_word", cur_word, 32'd0);
    check("rst_stripes", 32'(stripe_cnt), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;
    tick();

    // Two full stripes at k=4 with no backpressure
    exp_col = 0;
    load(8, 1, 4, 1'b1);
    cntrl_inbuff_rd_en = 1'b1;
    wait_sb("t1_done");
    cntrl_inbuff_rd_en = 1'b0;
    wait_idle("t1_idle");
    check("t1_latency", 32'(first_vld_cyc - first_rd_cyc), 32'd2);
    check("t1_thruput", 32'(last_xfer_cyc - first_vld_cyc), 32'd7);
    check("t1_stripes", 32'(stripe_cnt), 32'd2);
    check("t1_cfg_err", 32'(cfg_err), 32'd0);

    // Enable dropped after two pops: stripe is completed, nothing more popped
    exp_col = 0;
    load(4, 'h11, 4, 1'b1);
    load(2, 'h15, 4, 1'b0);
    p0 = pops;
    cntrl_inbuff_rd_en = 1'b1;
    n = 0;
    while ((pops - p0 < 2) && (n < 50)) begin
      tick();
      n++;
    end
    cntrl_inbuff_rd_en = 1'b0;
    wait_sb("t2_done");
    wait_idle("t2_idle");
    check("t2_pops", 32'(pops - p0), 32'd4);
    check("t2_left", 32'(fifo_n), 32'd2);
    repeat (5) tick();
    check("t2_no_more_pops", 32'(pops - p0), 32'd4);
    check("t2_stripes", 32'(stripe_cnt), 32'd3);
    fifo_q.delete();
    fifo_n = 0;

    // Backpressure mid-stripe
    exp_col = 0;
    load(8, 'h21, 4, 1'b1);
    p0 = xfers;
    cntrl_inbuff_rd_en = 1'b1;
    n = 0;
    while ((xfers - p0 < 2) && (n < 50)) begin
      tick();
      n++;
    end
    eng_data_rdy = 1'b0;
    repeat (5) tick();
    check("t3_rd_held", 32'(inbuff_rd), 32'd0);
    check("t3_vld", 32'(eng_data_vld), 32'd1);
    check("t3_buffered", 32'(pops - xfers), 32'd2);
    eng_data_rdy = 1'b1;
    wait_sb("t3_done");
    cntrl_inbuff_rd_en = 1'b0;
    wait_idle("t3_idle");
    check("t3_stripes", 32'(stripe_cnt), 32'd5);

    // Underrun after column 1 of a k=3 stripe
    k_cfg = 8'd3;
    exp_col = 0;
    load(2, 'h31, 3, 1'b1);
    cntrl_inbuff_rd_en = 1'b1;
    wait_sb("t4_part");
    repeat (3) tick();
    check("t4_vld_drop", 32'(eng_data_vld), 32'd0);
    check("t4_no_rd", 32'(inbuff_rd), 32'd0);
    check("t4_not_idle", 32'(rd_idle), 32'd0);
    load(1, 'h33, 3, 1'b1);
    wait_sb("t4_done");
    cntrl_inbuff_rd_en = 1'b0;
    wait_idle("t4_idle");
    check("t4_stripes", 32'(stripe_cnt), 32'd6);

    // Out-of-range widths are clamped; mid-run k_cfg changes are ignored
    k_cfg = 8'd1;
    exp_col = 0;
    load(4, 'h41, 2, 1'b1);
    cntrl_inbuff_rd_en = 1'b1;
    tick();
    k_cfg = 8'd7;
    wait_sb("t5a_done");
    cntrl_inbuff_rd_en = 1'b0;
    wait_idle("t5a_idle");
    check("t5a_cfg_err", 32'(cfg_err), 32'd1);
    check("t5a_stripes", 32'(stripe_cnt), 32'd8);
    k_cfg = 8'd200;
    exp_col = 0;
    load(128, 'h80, 128, 1'b1);
    cntrl_inbuff_rd_en = 1'b1;
    tick();
    k_cfg = 8'd4;
    wait_sb("t5b_done");
    cntrl_inbuff_rd_en = 1'b0;
    wait_idle("t5b_idle");
    check("t5b_cfg_err", 32'(cfg_err), 32'd1);
    check("t5b_stripes", 32'(stripe_cnt), 32'd9);

    // Reset mid-stripe with the skid full
    k_cfg = 8'd4;
    load(3, 'h61, 4, 1'b0);
    eng_data_rdy = 1'b0;
    cntrl_inbuff_rd_en = 1'b1;
    repeat (6) tick();
    check("t6_full_vld", 32'(eng_data_vld), 32'd1);
    check("t6_full", 32'(pops - xfers), 32'd2);
    rst = 1'b1;
    cntrl_inbuff_rd_en = 1'b0;
    tick();
    check("t6_vld", 32'(eng_data_vld), 32'd0);
    check("t6_rd", 32'(inbuff_rd), 32'd0);
    check("t6_word", cur_word, 32'd0);
    check("t6_stripes", 32'(stripe_cnt), 32'd0);
    check("t6_cfg_err", 32'(cfg_err), 32'd0);
    check("t6_idle", 32'(rd_idle), 32'd1);
    rst = 1'b0;
    fifo_q.delete();
    fifo_n = 0;
    exp_col = 0;
    load(4, 'h71, 4, 1'b1);
    eng_data_rdy = 1'b1;
    cntrl_inbuff_rd_en = 1'b1;
    wait_sb("t6_done");
    cntrl_inbuff_rd_en = 1'b0;
    wait_idle("t6_idle_end");
    check("t6_restripes", 32'(stripe_cnt), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
